alu_issue_ctrl: RTL and testbench

//  Multi-cycle issue/capture controller that drives the 64-bit datapath ALU's BusA/BusB/ALUCtrl inputs.
//  It sits between instruction sequencing and the ALU:
//  - accepts one LEGv8 opcode plus operands over a valid/ready request channel;
//  - decodes the opcode to ALUCtrl and registers the ALU inputs;
//  - captures BusW/Zero one cycle later and returns them over a valid/ready response channel.
//  The ALU instance stays outside this block and is wired to it at the datapath top level.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_opcode_decode.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, LEGv8 opcode patterns and issue FSM encoding
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_LSL   = 4'b1111;

    // '?' bits are don't-cares for casez matching
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDI = 11'b1001000100?;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_SUBI = 11'b1101000100?;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ANDI = 11'b1001001000?;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ORRI = 11'b1011001000?;
    localparam logic [10:0] OP_MOVZ = 11'b110100101??;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;

    typedef enum logic [1:0] {
        SEL_A_OPERAND = 2'd0,
        SEL_A_SHIFT   = 2'd1,
        SEL_A_ZERO    = 2'd2
    } sel_a_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_opcode_decode.sv
// rtl/alu_opcode_decode.sv - combinational LEGv8 opcode to ALU control / BusA select decode
module alu_opcode_decode
    import alu_pkg::*;
(
    input  logic [10:0] opcode_i,
    output logic [3:0]  ctrl_o,
    output sel_a_e      sel_a_o,
    output logic        legal_o
);

    always_comb begin
        ctrl_o  = ALU_AND;
        sel_a_o = SEL_A_OPERAND;
        legal_o = 1'b1;
        casez (opcode_i)
            OP_ADD, OP_LDUR, OP_STUR, OP_ADDI: ctrl_o = ALU_ADD;
            OP_SUB, OP_SUBI:                   ctrl_o = ALU_SUB;
            OP_AND, OP_ANDI:                   ctrl_o = ALU_AND;
            OP_ORR, OP_ORRI:                   ctrl_o = ALU_OR;
            OP_MOVZ: begin
                ctrl_o  = ALU_LSL;
                sel_a_o = SEL_A_SHIFT;
            end
            // CBZ passes Rt through so the ALU Zero flag is the branch condition
            OP_CBZ: begin
                ctrl_o  = ALU_PASSB;
                sel_a_o = SEL_A_ZERO;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - request/response issue controller driving an external 64-bit ALU
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int n = 64
)(
    input  logic         CLK,
    input  logic         Reset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic [10:0]  Opcode,
    input  logic [n-1:0] OperandA,
    input  logic [n-1:0] OperandB,
    input  logic [1:0]   ShiftAmt,
    output logic         RespValid,
    input  logic         RespReady,
    output logic [n-1:0] Result,
    output logic         ZeroOut,
    output logic         Illegal,
    output logic [n-1:0] AluBusA,
    output logic [n-1:0] AluBusB,
    output logic [3:0]   AluCtrl,
    input  logic [n-1:0] AluBusW,
    input  logic         AluZero
);

    state_e       state_q, state_d;
    logic         resp_valid_q, resp_valid_d;
    logic [n-1:0] result_q, result_d;
    logic         zero_q, zero_d;
    logic         illegal_q, illegal_d;
    logic [n-1:0] bus_a_q, bus_a_d;
    logic [n-1:0] bus_b_q, bus_b_d;
    logic [3:0]   ctrl_q, ctrl_d;

    logic [3:0]   dec_ctrl;
    sel_a_e       dec_sel_a;
    logic         dec_legal;
    logic [n-1:0] sel_bus_a;

    alu_opcode_decode u_decode (
        .opcode_i (Opcode),
        .ctrl_o   (dec_ctrl),
        .sel_a_o  (dec_sel_a),
        .legal_o  (dec_legal)
    );

    always_comb begin
        case (dec_sel_a)
            SEL_A_SHIFT: sel_bus_a = {{(n-2){1'b0}}, ShiftAmt};
            SEL_A_ZERO:  sel_bus_a = '0;
            default:     sel_bus_a = OperandA;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
            bus_a_q      <= '0;
            bus_b_q      <= '0;
            ctrl_q       <= ALU_AND;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            illegal_q    <= illegal_d;
            bus_a_q      <= bus_a_d;
            bus_b_q      <= bus_b_d;
            ctrl_q       <= ctrl_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
        illegal_d    = illegal_q;
        bus_a_d      = bus_a_q;
        bus_b_d      = bus_b_q;
        ctrl_d       = ctrl_q;
        case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    if (dec_legal) begin
                        bus_a_d = sel_bus_a;
                        bus_b_d = OperandB;
                        ctrl_d  = dec_ctrl;
                        state_d = ST_ISSUE;
                    end else begin
                        // ALU inputs keep their previous values on an illegal op
                        illegal_d = 1'b1;
                        result_d  = '0;
                        zero_d    = 1'b0;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                result_d  = AluBusW;
                zero_d    = AluZero;
                illegal_d = 1'b0;
                state_d   = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                // an illegal op enters RESP with valid still low; raise it here
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (RespReady) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ReqReady  = (state_q == ST_IDLE);
    assign RespValid = resp_valid_q;
    assign Result    = result_q;
    assign ZeroOut   = zero_q;
    assign Illegal   = illegal_q;
    assign AluBusA   = bus_a_q;
    assign AluBusB   = bus_b_q;
    assign AluCtrl   = ctrl_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [10:0] Opcode;
    logic [63:0] OperandA;
    logic [63:0] OperandB;
    logic [1:0]  ShiftAmt;
    logic        RespValid;
    logic        RespReady;
    logic [63:0] Result;
    logic        ZeroOut;
    logic        Illegal;
    logic [63:0] AluBusA;
    logic [63:0] AluBusB;
    logic [3:0]  AluCtrl;
    logic [63:0] AluBusW;
    logic        AluZero;

    always #5 CLK = ~CLK;

    alu_issue_ctrl #(.n(64)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .Opcode    (Opcode),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .ShiftAmt  (ShiftAmt),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .Result    (Result),
        .ZeroOut   (ZeroOut),
        .Illegal   (Illegal),
        .AluBusA   (AluBusA),
        .AluBusB   (AluBusB),
        .AluCtrl   (AluCtrl),
        .AluBusW   (AluBusW),
        .AluZero   (AluZero)
    );

    // external datapath ALU stand-in
    always_comb begin
        case (AluCtrl)
            4'b0000: AluBusW = AluBusA & AluBusB;
            4'b0001: AluBusW = AluBusA | AluBusB;
            4'b0010: AluBusW = AluBusA + AluBusB;
            4'b0110: AluBusW = AluBusA - AluBusB;
            4'b0111: AluBusW = AluBusB;
            4'b1111: AluBusW = AluBusB << {AluBusA[1:0], 4'b0000};
            default: AluBusW = 64'd0;
        endcase
    end
    assign AluZero = (AluBusW == 64'd0);

    typedef struct {
        logic [10:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  sh;
        logic [63:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
        logic [3:0]  exp_ctrl;
        logic [63:0] exp_busa;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        ill;
    } resp_t;

    int    checks = 0;
    int    errors = 0;
    resp_t exp_q[$];
    vec_t  vecs[18];
    logic [3:0]  last_ctrl = 4'b0000;
    logic [63:0] last_a    = 64'd0;
    logic [63:0] last_b    = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] sh, input logic [63:0] res, input logic zero,
                                input logic ill, input logic [3:0] ctrl, input logic [63:0] busa);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh;
        v.exp_res = res; v.exp_zero = zero; v.exp_ill = ill;
        v.exp_ctrl = ctrl; v.exp_busa = busa;
        return v;
    endfunction

    // scoreboard: every completed response handshake pops one expectation
    always @(negedge CLK) begin
        if (!Reset && RespValid && RespReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 64'd1, 64'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_result", Result, e.res);
                chk("resp_zero", {63'd0, ZeroOut}, {63'd0, e.zero});
                chk("resp_illegal", {63'd0, Illegal}, {63'd0, e.ill});
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v, input int stall);
        int    n;
        int    lat;
        bit    seen;
        resp_t e;
        n = 0;
        @(negedge CLK);
        while (!ReqReady && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!ReqReady) begin
            checks++; errors++;
            $display("FAIL ready_timeout v%0d: ReqReady stayed 0, required 1", idx);
            return;
        end
        @(posedge CLK); #1;
        ReqValid  = 1'b1;
        Opcode    = v.op;
        OperandA  = v.a;
        OperandB  = v.b;
        ShiftAmt  = v.sh;
        RespReady = (stall == 0);
        @(posedge CLK);
        e.res = v.exp_res; e.zero = v.exp_zero; e.ill = v.exp_ill;
        exp_q.push_back(e);
        #1;
        // later changes to request fields must not leak into the op in flight
        ReqValid = (stall > 0);
        Opcode   = 11'b11001011000;
        OperandA = {$urandom, $urandom};
        OperandB = {$urandom, $urandom};
        ShiftAmt = ~v.sh;
        @(negedge CLK);
        if (!v.exp_ill) begin
            chk($sformatf("alu_ctrl v%0d", idx), {60'd0, AluCtrl}, {60'd0, v.exp_ctrl});
            chk($sformatf("alu_busa v%0d", idx), AluBusA, v.exp_busa);
            chk($sformatf("alu_busb v%0d", idx), AluBusB, v.b);
            last_ctrl = v.exp_ctrl;
            last_a    = v.exp_busa;
            last_b    = v.b;
        end else begin
            chk($sformatf("alu_ctrl_held v%0d", idx), {60'd0, AluCtrl}, {60'd0, last_ctrl});
            chk($sformatf("alu_busa_held v%0d", idx), AluBusA, last_a);
            chk($sformatf("alu_busb_held v%0d", idx), AluBusB, last_b);
        end
        lat  = 0;
        seen = RespValid;
        while (!seen && lat < 10) begin
            @(negedge CLK);
            lat++;
            seen = RespValid;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL resp_timeout v%0d: RespValid stayed 0, required 1", idx);
            void'(exp_q.pop_back());
            return;
        end
        chk($sformatf("latency v%0d", idx), lat, v.exp_ill ? 64'd1 : 64'd2);
        chk($sformatf("ready_low_in_resp v%0d", idx), {63'd0, ReqReady}, 64'd0);
        if (stall > 0) begin
            repeat (stall) begin
                @(negedge CLK);
                chk($sformatf("stall_result v%0d", idx), Result, v.exp_res);
                chk($sformatf("stall_valid v%0d", idx), {63'd0, RespValid}, 64'd1);
                chk($sformatf("stall_ready v%0d", idx), {63'd0, ReqReady}, 64'd0);
            end
            @(posedge CLK); #1;
            ReqValid  = 1'b0;
            RespReady = 1'b1;
            @(negedge CLK);
            @(posedge CLK);
        end else begin
            @(posedge CLK);
        end
        @(negedge CLK);
        chk($sformatf("valid_cleared v%0d", idx), {63'd0, RespValid}, 64'd0);
        chk($sformatf("ready_back v%0d", idx), {63'd0, ReqReady}, 64'd1);
    endtask

    initial begin
        bit spurious;
        vecs[0]  = mk(11'b10001011000, 64'd5, 64'd7, 2'd0, 64'd12, 1'b0, 1'b0, 4'b0010, 64'd5);
        vecs[1]  = mk(11'b11010001001, 64'd9, 64'd9, 2'd0, 64'd0, 1'b1, 1'b0, 4'b0110, 64'd9);
        vecs[2]  = mk(11'b11010010110, 64'h1234, 64'hBEEF, 2'd2, 64'h0000_BEEF_0000_0000, 1'b0, 1'b0, 4'b1111, 64'd2);
        vecs[3]  = mk(11'b10110100000, 64'h55, 64'd0, 2'd0, 64'd0, 1'b1, 1'b0, 4'b0111, 64'd0);
        vecs[4]  = mk(11'b10110100111, 64'h55, 64'd1, 2'd0, 64'd1, 1'b0, 1'b0, 4'b0111, 64'd0);
        vecs[5]  = mk(11'h000, 64'd3, 64'd4, 2'd0, 64'd0, 1'b0, 1'b1, 4'b0000, 64'd0);
        vecs[6]  = mk(11'b10001010000, 64'hFF0F, 64'h0F0F, 2'd0, 64'h0F0F, 1'b0, 1'b0, 4'b0000, 64'hFF0F);
        vecs[7]  = mk(11'b10101010000, 64'hF000, 64'h000F, 2'd0, 64'hF00F, 1'b0, 1'b0, 4'b0001, 64'hF000);
        vecs[8]  = mk(11'b11111000010, 64'h100, 64'h8, 2'd0, 64'h108, 1'b0, 1'b0, 4'b0010, 64'h100);
        vecs[9]  = mk(11'b11111000000, 64'h20, 64'h10, 2'd0, 64'h30, 1'b0, 1'b0, 4'b0010, 64'h20);
        vecs[10] = mk(11'b10010001000, 64'd3, 64'd4, 2'd0, 64'd7, 1'b0, 1'b0, 4'b0010, 64'd3);
        vecs[11] = mk(11'b11001011000, 64'd0, 64'd1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'b0110, 64'd0);
        vecs[12] = mk(11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 64'd0, 1'b1, 1'b0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[13] = mk(11'b10010010001, 64'hF, 64'd3, 2'd0, 64'd3, 1'b0, 1'b0, 4'b0000, 64'hF);
        vecs[14] = mk(11'b10110010000, 64'h10, 64'd1, 2'd0, 64'h11, 1'b0, 1'b0, 4'b0001, 64'h10);
        vecs[15] = mk(11'h7FF, 64'd8, 64'd9, 2'd3, 64'd0, 1'b0, 1'b1, 4'b0000, 64'd0);
        vecs[16] = mk(11'b11010010101, 64'd0, 64'hBEEF, 2'd3, 64'hBEEF_0000_0000_0000, 1'b0, 1'b0, 4'b1111, 64'd3);
        vecs[17] = mk(11'b11010010100, 64'd7, 64'hBEEF, 2'd0, 64'hBEEF, 1'b0, 1'b0, 4'b1111, 64'd0);

        Reset = 1'b1; ReqValid = 1'b0; RespReady = 1'b1;
        Opcode = 11'd0; OperandA = 64'd0; OperandB = 64'd0; ShiftAmt = 2'd0;
        @(negedge CLK);
        chk("rst_ready", {63'd0, ReqReady}, 64'd1);
        chk("rst_valid", {63'd0, RespValid}, 64'd0);
        chk("rst_result", Result, 64'd0);
        chk("rst_flags", {62'd0, ZeroOut, Illegal}, 64'd0);
        chk("rst_alu", AluBusA | AluBusB | {60'd0, AluCtrl}, 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(i, vecs[i], 0);

        // response back-pressure with a competing request held high
        run_vec(100, vecs[0], 5);
        run_vec(101, vecs[5], 3);

        // reset while the op is in ISSUE
        @(negedge CLK);
        @(posedge CLK); #1;
        ReqValid = 1'b1; Opcode = 11'b10001011000; OperandA = 64'd40; OperandB = 64'd2; ShiftAmt = 2'd0;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        @(negedge CLK);
        chk("pre_rst_ctrl", {60'd0, AluCtrl}, 64'b0010);
        Reset = 1'b1;
        #1;
        chk("midrst_ready", {63'd0, ReqReady}, 64'd1);
        chk("midrst_valid", {63'd0, RespValid}, 64'd0);
        chk("midrst_result", Result, 64'd0);
        chk("midrst_flags", {62'd0, ZeroOut, Illegal}, 64'd0);
        chk("midrst_busa", AluBusA, 64'd0);
        chk("midrst_busb", AluBusB, 64'd0);
        chk("midrst_ctrl", {60'd0, AluCtrl}, 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        spurious = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (RespValid) spurious = 1'b1;
        end
        chk("no_resp_after_reset", {63'd0, spurious}, 64'd0);
        chk("scoreboard_empty", exp_q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
